// File: rtl/ldpc_qc_pkg.sv
// Shared constants for the QC-LDPC code: geometry, circulant shift table and checker states.
// The encoder-side parity-check matrix is built from these same shift constants.
package ldpc_qc_pkg;

    localparam int Z      = 512;
    localparam int NCOL   = 18;
    localparam int NROW   = 2;
    localparam int DW     = 64;
    localparam int SHW    = 9;
    localparam int BEATS  = Z / DW;
    localparam int BEAT_W = 3;
    localparam int BLK_W  = 5;

    // Column 0 occupies the least significant 9 bits; column 17 the most significant.
    localparam logic [NCOL*SHW-1:0] ROW0_SHIFT = {
        9'd110, 9'd167, 9'd128, 9'd332, 9'd90,  9'd487, 9'd218, 9'd69,  9'd52,
        9'd21,  9'd474, 9'd465, 9'd310, 9'd501, 9'd151, 9'd10,  9'd0,   9'd122
    };

    localparam logic [NCOL*SHW-1:0] ROW1_SHIFT = {
        9'd32,  9'd134, 9'd219, 9'd394, 9'd91,  9'd463, 9'd179, 9'd213, 9'd329,
        9'd447, 9'd175, 9'd511, 9'd16,  9'd54,  9'd143, 9'd370, 9'd367, 9'd381
    };

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        APPLY  = 2'd1,
        RESULT = 2'd2
    } state_t;

    // Table lookup written as a compare chain so an out-of-range block index never forms a bad select.
    function automatic logic [SHW-1:0] shift_of(input logic [NCOL*SHW-1:0] tbl,
                                                input logic [BLK_W-1:0]    col);
        logic [SHW-1:0] sh;
        sh = '0;
        for (int i = 0; i < NCOL; i++) begin
            if (col == BLK_W'(i)) begin
                sh = tbl[SHW*i +: SHW];
            end
        end
        return sh;
    endfunction

endpackage

// File: rtl/qc_rotate.sv
// Combinational barrel right-rotate: dout[i] = din[(i + amt) mod W], one log stage per amount bit.
module qc_rotate
    import ldpc_qc_pkg::*;
#(
    parameter int W  = Z,
    parameter int AW = SHW
) (
    input  logic [W-1:0]  din,
    input  logic [AW-1:0] amt,
    output logic [W-1:0]  dout
);

    logic [W-1:0] stg [0:AW];

    assign stg[0] = din;

    for (genvar k = 0; k < AW; k++) begin : g_stage
        localparam int SH = 1 << k;
        assign stg[k+1] = amt[k] ? {stg[k][SH-1:0], stg[k][W-1:SH]} : stg[k];
    end

    assign dout = stg[AW];

endmodule

// File: rtl/ldpc_syndrome_check.sv
// Streaming QC-LDPC syndrome checker: buffers each 512-bit block, then folds its rotated
// copies into the two row accumulators and reports the syndrome with a pass flag.
module ldpc_syndrome_check
    import ldpc_qc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NROW*Z-1:0]   syn_out,
    output logic                syn_ok
);

    state_t            state;
    state_t            state_next;
    logic [BEAT_W-1:0] beat;
    logic [BLK_W-1:0]  blk;
    logic [Z-1:0]      blk_buf;
    logic [Z-1:0]      acc0;
    logic [Z-1:0]      acc1;
    logic [Z-1:0]      rot0;
    logic [Z-1:0]      rot1;
    logic [SHW-1:0]    sh0;
    logic [SHW-1:0]    sh1;
    logic              beat_fire;
    logic              last_beat;
    logic              last_blk;
    logic              res_fire;

    // Held low while rst is asserted so the interface reads idle during reset.
    assign in_ready  = (state == LOAD) && !rst;
    assign beat_fire = in_valid && in_ready;
    assign last_beat = (beat == BEAT_W'(BEATS - 1));
    assign last_blk  = (blk == BLK_W'(NCOL - 1));
    assign res_fire  = out_valid && out_ready;

    assign sh0 = shift_of(ROW0_SHIFT, blk);
    assign sh1 = shift_of(ROW1_SHIFT, blk);

    qc_rotate #(.W(Z), .AW(SHW)) u_rot0 (
        .din  (blk_buf),
        .amt  (sh0),
        .dout (rot0)
    );

    qc_rotate #(.W(Z), .AW(SHW)) u_rot1 (
        .din  (blk_buf),
        .amt  (sh1),
        .dout (rot1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (beat_fire && last_beat) state_next = APPLY;
            APPLY:   state_next = last_blk ? RESULT : LOAD;
            RESULT:  if (res_fire) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    // Block buffer is pure data: every bit is rewritten before it is ever consumed.
    always_ff @(posedge clk) begin
        if (beat_fire) begin
            blk_buf[DW*beat +: DW] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat      <= '0;
            blk       <= '0;
            acc0      <= '0;
            acc1      <= '0;
            out_valid <= 1'b0;
            syn_out   <= '0;
            syn_ok    <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (beat_fire) begin
                        beat <= beat + 1'b1;
                    end
                end
                APPLY: begin
                    acc0 <= acc0 ^ rot0;
                    acc1 <= acc1 ^ rot1;
                    beat <= '0;
                    if (!last_blk) begin
                        blk <= blk + 1'b1;
                    end
                end
                RESULT: begin
                    // First RESULT cycle registers the syndrome; it then holds until accepted.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        syn_out   <= {acc1, acc0};
                        syn_ok    <= ~|{acc1, acc0};
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        acc0      <= '0;
                        acc1      <= '0;
                        blk       <= '0;
                        beat      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ldpc_syndrome_check.sv
// Directed-plus-random bench for ldpc_syndrome_check against a bit-level syndrome model.
module tb_ldpc_syndrome_check;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic          out_valid;
    logic          out_ready;
    logic [1023:0] syn_out;
    logic          syn_ok;

    int n_assert = 0;
    int n_fail   = 0;

    logic [511:0] cw [18];

    // Shift values indexed by column 0..17.
    int S0 [18] = '{122, 0, 10, 151, 501, 310, 465, 474, 21, 52, 69, 218, 487, 90, 332, 128, 167, 110};
    int S1 [18] = '{381, 367, 370, 143, 54, 16, 511, 175, 447, 329, 213, 179, 463, 91, 394, 219, 134, 32};

    ldpc_syndrome_check dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .syn_out   (syn_out),
        .syn_ok    (syn_ok)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [1023:0] ref_syndrome();
        logic [1023:0] s;
        int sh;
        s = '0;
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 18; j++) begin
                sh = (r == 0) ? S0[j] : S1[j];
                for (int i = 0; i < 512; i++) begin
                    s[r*512 + i] = s[r*512 + i] ^ cw[j][(i + sh) % 512];
                end
            end
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_syn(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed ones=%0d low=%h expected ones=%0d low=%h",
                   tag, $countones(obs), obs[63:0], $countones(exp), exp[63:0]);
        end
    endtask

    task automatic clear_cw();
        for (int j = 0; j < 18; j++) cw[j] = '0;
    endtask

    task automatic random_cw();
        for (int j = 0; j < 18; j++) begin
            for (int w = 0; w < 16; w++) cw[j][32*w +: 32] = $urandom();
        end
    endtask

    // Streams up to max_beats beats of cw, idling in_valid with probability gap_pct.
    task automatic send_frame(input int gap_pct, input int max_beats);
        int  sent;
        int  guard;
        bit  done;
        sent  = 0;
        guard = 0;
        for (int j = 0; j < 18; j++) begin
            for (int k = 0; k < 8; k++) begin
                if (sent < max_beats && guard < 5000) begin
                    done = 1'b0;
                    while (!done && guard < 5000) begin
                        @(negedge clk);
                        if (int'($urandom_range(99)) < gap_pct) begin
                            in_valid = 1'b0;
                            in_data  = {$urandom(), $urandom()};
                        end else begin
                            in_valid = 1'b1;
                            in_data  = cw[j][64*k +: 64];
                        end
                        done = in_valid && in_ready;
                        @(posedge clk);
                        guard++;
                    end
                    if (done) sent++;
                end
            end
        end
        chk("frame_beats_accepted", 64'(sent), 64'(max_beats));
    endtask

    // lat counts falling edges after the last beat's rising edge until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 100);
        chk("result_valid", out_valid, 1);
    endtask

    task automatic finish_result(input string tag, input logic [1023:0] exp);
        logic [1023:0] held;
        chk_syn({tag, "_syn"}, syn_out, exp);
        chk({tag, "_ok"}, syn_ok, (exp == '0) ? 64'd1 : 64'd0);
        chk({tag, "_ready_in_result"}, in_ready, 0);
        held      = syn_out;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_cleared"}, out_valid, 0);
        chk_syn({tag, "_syn_kept"}, syn_out, held);
    endtask

    initial begin
        logic [1023:0] exp;
        logic [1023:0] saved;
        logic [1023:0] held;
        int            lat;
        int            bit_pos;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        clear_cw();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk_syn("reset_syn_out", syn_out, '0);
        chk("reset_syn_ok", syn_ok, 0);
        rst = 1'b0;

        // All-zero codeword with out_ready held high.
        out_ready = 1'b1;
        clear_cw();
        send_frame(0, 144);
        wait_result(lat);
        chk("zero_latency", 64'(lat), 64'd3);
        finish_result("zero", '0);

        // Single bit in block 0.
        clear_cw();
        cw[0][0] = 1'b1;
        exp = '0;
        exp[390] = 1'b1;
        exp[643] = 1'b1;
        send_frame(0, 144);
        wait_result(lat);
        finish_result("blk0_bit0", exp);

        // Single bit in block 17.
        clear_cw();
        cw[17][0] = 1'b1;
        exp = '0;
        exp[402] = 1'b1;
        exp[992] = 1'b1;
        send_frame(0, 144);
        wait_result(lat);
        finish_result("blk17_bit0", exp);

        // Random codeword, gap-free.
        random_cw();
        saved = ref_syndrome();
        send_frame(0, 144);
        wait_result(lat);
        finish_result("rand_nogap", saved);

        // Same codeword with input gaps and a stalled result.
        send_frame(50, 144);
        wait_result(lat);
        held = syn_out;
        repeat (10) begin
            in_valid = 1'b1;
            in_data  = {$urandom(), $urandom()};
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk_syn("stall_syn_stable", syn_out, held);
            chk("stall_no_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        finish_result("rand_gap", saved);

        // Abort at block 9 beat 3, then a clean all-zero frame.
        random_cw();
        send_frame(0, 75);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk_syn("midrst_syn_out", syn_out, '0);
        chk("midrst_syn_ok", syn_ok, 0);
        rst = 1'b0;
        clear_cw();
        send_frame(0, 144);
        wait_result(lat);
        finish_result("after_rst", '0);

        // Back-to-back: single-bit error, then all-zero.
        clear_cw();
        bit_pos = int'($urandom_range(9215));
        cw[bit_pos / 512][bit_pos % 512] = 1'b1;
        exp = ref_syndrome();
        send_frame(0, 144);
        wait_result(lat);
        finish_result("b2b_err", exp);
        clear_cw();
        send_frame(0, 144);
        wait_result(lat);
        finish_result("b2b_zero", '0);

        // Further random frames with moderate gaps.
        repeat (2) begin
            random_cw();
            exp = ref_syndrome();
            send_frame(30, 144);
            wait_result(lat);
            finish_result("rand_gap30", exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
